ifetch_bp: RTL and testbench

Parametrised instruction-fetch stage with dynamic branch prediction. It holds the PC and decodes the fetched 16-bit instruction just far enough to find branches. A table of 2-bit saturating counters predicts conditional branches, and the stage redirects on `jr` or on mispredictions reported by EX. It sits between instruction memory and the IF/ID register and feeds `pc`/`pc+1`/prediction downstream.

---
 rtl/ifetch_pkg.sv | 26 ++
 rtl/ifetch_bp_if.sv | 32 +++
 rtl/ifetch_bp_bht.sv | 34 +++
 rtl/ifetch_bp.sv | 81 ++++++++
 tb/tb_ifetch_bp.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch stage: branch opcodes,
// 2-bit predictor counter encodings and the immediate sign-extend helper.
package ifetch_pkg;

  localparam logic [4:0] OP_B    = 5'b00010;
  localparam logic [4:0] OP_BEQZ = 5'b00100;
  localparam logic [4:0] OP_BNEZ = 5'b00101;
  localparam logic [4:0] OP_BTX  = 5'b01100;

  typedef enum logic [1:0] {
    CTR_SN = 2'b00,
    CTR_WN = 2'b01,
    CTR_WT = 2'b10,
    CTR_ST = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RESET = CTR_WN;

  // Sign-extends either imm8 (field[7:0]) or imm11 (field[10:0]) to 64 bits;
  // callers truncate to their PC width, which keeps arithmetic modulo 2^PC_WIDTH.
  function automatic logic [63:0] sign_ext(input logic [10:0] field, input logic short_imm);
    if (short_imm) return {{56{field[7]}}, field[7:0]};
    else           return {{53{field[10]}}, field};
  endfunction

endpackage

// File: rtl/ifetch_bp_if.sv
// Fetch-stage bus: imem instruction in, redirect/resolve inputs from the
// pipeline, PC and prediction outputs toward IF/ID.
interface ifetch_bp_if #(parameter int PC_WIDTH = 16);

  logic                stall_pc_i;
  logic [15:0]         instr_i;
  logic                jr_i;
  logic [PC_WIDTH-1:0] address_jr_i;
  logic                resolve_valid_i;
  logic [PC_WIDTH-1:0] resolve_pc_i;
  logic                resolve_taken_i;
  logic [PC_WIDTH-1:0] resolve_target_i;
  logic                resolve_pred_i;
  logic [PC_WIDTH-1:0] pc_o;
  logic [PC_WIDTH-1:0] pcplus1_o;
  logic                pred_taken_o;
  logic                flush_o;
  logic [PC_WIDTH-1:0] epc_o;

  modport master (
    output stall_pc_i, instr_i, jr_i, address_jr_i,
    output resolve_valid_i, resolve_pc_i, resolve_taken_i, resolve_target_i, resolve_pred_i,
    input  pc_o, pcplus1_o, pred_taken_o, flush_o, epc_o
  );

  modport slave (
    input  stall_pc_i, instr_i, jr_i, address_jr_i,
    input  resolve_valid_i, resolve_pc_i, resolve_taken_i, resolve_target_i, resolve_pred_i,
    output pc_o, pcplus1_o, pred_taken_o, flush_o, epc_o
  );

endinterface

// File: rtl/ifetch_bp_bht.sv
// Untagged branch history table of 2-bit saturating counters. Combinational
// read; write lands on the clock edge, so a same-cycle read sees the old value.
module bht
  import ifetch_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output ctr_e             rd_ctr,
  input  logic             wr_valid,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  ctr_e ctr [DEPTH];

  assign rd_ctr = ctr[rd_idx];

  // Reset reinitialises every counter in one edge; otherwise saturating update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ctr[i] <= CTR_RESET;
    end else if (wr_valid) begin
      if (wr_taken && ctr[wr_idx] != CTR_ST)
        ctr[wr_idx] <= ctr_e'(ctr[wr_idx] + 2'd1);
      else if (!wr_taken && ctr[wr_idx] != CTR_SN)
        ctr[wr_idx] <= ctr_e'(ctr[wr_idx] - 2'd1);
    end
  end

endmodule

// File: rtl/ifetch_bp.sv
// Instruction-fetch stage: holds the PC, partially decodes the fetched
// instruction to find branches, predicts via the BHT and applies redirects.
module ifetch_bp
  import ifetch_pkg::*;
#(
  parameter int                  PC_WIDTH  = 16,
  parameter int                  BHT_DEPTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
  input logic         CLK,
  input logic         RST,
  ifetch_bp_if.slave  bus
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [PC_WIDTH-1:0] pc, pc_lock, epc, next_pc, imm, pc_plus1;
  logic [4:0]          op;
  logic                is_b, is_cond, ctr_taken, pred_taken, mispredict;
  ctr_e                rd_ctr;

  bht #(.DEPTH(BHT_DEPTH)) u_bht (
    .clk      (CLK),
    .rst      (RST),
    .rd_idx   (pc[IDX_W-1:0]),
    .rd_ctr   (rd_ctr),
    .wr_valid (bus.resolve_valid_i),
    .wr_idx   (bus.resolve_pc_i[IDX_W-1:0]),
    .wr_taken (bus.resolve_taken_i)
  );

  assign op         = bus.instr_i[15:11];
  assign pc_plus1   = pc + PC_WIDTH'(1);
  assign ctr_taken  = (rd_ctr == CTR_WT) || (rd_ctr == CTR_ST);
  assign mispredict = bus.resolve_valid_i && (bus.resolve_taken_i != bus.resolve_pred_i);

  // Branch decode and zero-latency prediction from the current pc/instruction.
  always_comb begin
    is_b       = (op == OP_B);
    is_cond    = (op == OP_BEQZ) || (op == OP_BNEZ) ||
                 ((op == OP_BTX) && (bus.instr_i[10:9] == 2'b00));
    imm        = PC_WIDTH'(sign_ext(bus.instr_i[10:0], !is_b));
    pred_taken = !RST && (is_b || (is_cond && ctr_taken));
  end

  // Next-PC selection; redirects outrank stall, jr outranks mispredict.
  always_comb begin
    next_pc = pc_plus1;
    if (bus.jr_i)
      next_pc = bus.address_jr_i;
    else if (mispredict)
      next_pc = bus.resolve_taken_i ? bus.resolve_target_i : bus.resolve_pc_i + PC_WIDTH'(1);
    else if (bus.stall_pc_i)
      next_pc = pc;
    else if (pred_taken)
      next_pc = pc_plus1 + imm;
  end

  // PC, previous-cycle PC and exception-PC registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc      <= RESET_PC;
      pc_lock <= RESET_PC;
      epc     <= '0;
    end else begin
      pc      <= next_pc;
      pc_lock <= pc;
      if (bus.jr_i)
        epc <= pc_lock;
      else if (mispredict)
        epc <= bus.resolve_pc_i;
    end
  end

  assign bus.pc_o         = pc;
  assign bus.pcplus1_o    = pc_plus1;
  assign bus.pred_taken_o = pred_taken;
  assign bus.flush_o      = !RST && (bus.jr_i || mispredict);
  assign bus.epc_o        = epc;

endmodule

// File: tb/tb_ifetch_bp.sv
// Scoreboard bench for ifetch_bp: expectations are queued when stimulus is
// applied and popped/compared once the DUT output for that step is valid.
module tb_ifetch_bp;
  import ifetch_pkg::*;

  localparam int PW    = 16;
  localparam int DEPTH = 16;

  localparam int S_PC = 0, S_PC1 = 1, S_PRED = 2, S_FLUSH = 3, S_EPC = 4;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  logic [1:0] model_ctr [DEPTH];

  ifetch_bp_if #(.PC_WIDTH(PW)) bus ();

  ifetch_bp #(.PC_WIDTH(PW), .BHT_DEPTH(DEPTH), .RESET_PC(16'h0040)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      S_PC:    return bus.pc_o;
      S_PC1:   return bus.pcplus1_o;
      S_PRED:  return {15'd0, bus.pred_taken_o};
      S_FLUSH: return {15'd0, bus.flush_o};
      default: return bus.epc_o;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic settle();
    #2;
    drain();
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    drain();
  endtask

  task automatic idle();
    bus.stall_pc_i       = 1'b0;
    bus.instr_i          = 16'h0000;
    bus.jr_i             = 1'b0;
    bus.address_jr_i     = '0;
    bus.resolve_valid_i  = 1'b0;
    bus.resolve_pc_i     = '0;
    bus.resolve_taken_i  = 1'b0;
    bus.resolve_target_i = '0;
    bus.resolve_pred_i   = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_ctr[i] = 2'b01;
  endtask

  task automatic resolve(input logic [15:0] rpc, input logic taken,
                         input logic [15:0] target, input logic pred);
    int idx;
    bus.resolve_valid_i  = 1'b1;
    bus.resolve_pc_i     = rpc;
    bus.resolve_taken_i  = taken;
    bus.resolve_target_i = target;
    bus.resolve_pred_i   = pred;
    idx = int'(rpc[3:0]);
    if (taken && model_ctr[idx] != 2'b11) model_ctr[idx] = model_ctr[idx] + 2'd1;
    else if (!taken && model_ctr[idx] != 2'b00) model_ctr[idx] = model_ctr[idx] - 2'd1;
  endtask

  task automatic jump(input logic [15:0] addr);
    idle();
    bus.jr_i         = 1'b1;
    bus.address_jr_i = addr;
    tick();
  endtask

  initial begin
    idle();
    model_reset();

    // reset: outputs forced quiet even with a branch and jr present
    RST = 1'b1;
    bus.instr_i = 16'h17FE;
    bus.jr_i = 1'b1;
    bus.address_jr_i = 16'h1234;
    push("rst_pred", S_PRED, 16'd0);
    push("rst_flush", S_FLUSH, 16'd0);
    settle();
    push("rst_pc", S_PC, 16'h0040);
    push("rst_pc1", S_PC1, 16'h0041);
    push("rst_epc", S_EPC, 16'h0000);
    tick();

    // free run
    RST = 1'b0;
    idle();
    push("run_pred", S_PRED, 16'd0);
    settle();
    tick();
    tick();
    push("run_pc3", S_PC, 16'h0043);
    tick();

    // jr to 0x10; epc captures pc of the cycle before (0x42)
    idle();
    bus.jr_i = 1'b1;
    bus.address_jr_i = 16'h0010;
    push("jr_flush", S_FLUSH, 16'd1);
    settle();
    push("jr_pc", S_PC, 16'h0010);
    push("jr_epc", S_EPC, 16'h0042);
    tick();

    // unconditional B with imm -2
    idle();
    bus.instr_i = 16'h17FE;
    push("b_pred", S_PRED, 16'd1);
    push("b_flush", S_FLUSH, 16'd0);
    settle();
    push("b_pc", S_PC, 16'h000F);
    push("b_pc1", S_PC1, 16'h0010);
    tick();

    // BEQZ +4 with a fresh counter predicts not taken
    jump(16'h0020);
    idle();
    bus.instr_i = 16'h2004;
    push("beqz_wn_pred", S_PRED, {15'd0, model_ctr[0][1]});
    settle();
    push("beqz_wn_pc", S_PC, 16'h0021);
    tick();

    // EX reports taken, predicted not taken
    idle();
    resolve(16'h0020, 1'b1, 16'h0025, 1'b0);
    push("mp_flush", S_FLUSH, 16'd1);
    settle();
    push("mp_pc", S_PC, 16'h0025);
    push("mp_epc", S_EPC, 16'h0020);
    tick();

    // refetch now predicts taken
    jump(16'h0020);
    idle();
    bus.instr_i = 16'h2004;
    push("beqz_wt_pred", S_PRED, {15'd0, model_ctr[0][1]});
    settle();
    push("beqz_wt_pc", S_PC, 16'h0025);
    tick();

    // four correctly predicted taken resolves on index 3
    for (int k = 0; k < 4; k++) begin
      idle();
      resolve(16'h0033, 1'b1, 16'h0040, 1'b1);
      push("sat_noflush", S_FLUSH, 16'd0);
      settle();
      tick();
    end
    // one not-taken (mispredicted) resolve: redirect to pc+1
    idle();
    resolve(16'h0033, 1'b0, 16'h0040, 1'b1);
    push("nt_flush", S_FLUSH, 16'd1);
    settle();
    push("nt_pc", S_PC, 16'h0034);
    push("nt_epc", S_EPC, 16'h0033);
    tick();
    jump(16'h0033);
    idle();
    bus.instr_i = 16'h2803;
    push("sat_pred", S_PRED, {15'd0, model_ctr[3][1]});
    settle();
    push("sat_pc", S_PC, {15'd0, model_ctr[3][1]} == 16'd1 ? 16'h0037 : 16'h0034);
    tick();

    // second not-taken drops to WN; BTEQZ then predicts not taken
    idle();
    resolve(16'h0033, 1'b0, 16'h0040, 1'b1);
    settle();
    tick();
    jump(16'h0033);
    idle();
    bus.instr_i = 16'h6003;
    push("btx_pred", S_PRED, {15'd0, model_ctr[3][1]});
    settle();
    push("btx_pc", S_PC, 16'h0034);
    tick();

    // stall holds pc; jr during stall redirects
    jump(16'h0050);
    idle();
    bus.stall_pc_i = 1'b1;
    push("stall_pc1", S_PC, 16'h0050);
    tick();
    push("stall_pc2", S_PC, 16'h0050);
    tick();
    bus.jr_i = 1'b1;
    bus.address_jr_i = 16'h1234;
    push("stall_jr_flush", S_FLUSH, 16'd1);
    settle();
    push("stall_jr_pc", S_PC, 16'h1234);
    tick();

    // jr and mispredict together: jr wins pc/epc, BHT still updates
    idle();
    bus.jr_i = 1'b1;
    bus.address_jr_i = 16'h0100;
    resolve(16'h0007, 1'b1, 16'h0200, 1'b0);
    push("both_flush", S_FLUSH, 16'd1);
    settle();
    push("both_pc", S_PC, 16'h0100);
    push("both_epc", S_EPC, 16'h0050);
    tick();
    jump(16'h0007);
    idle();
    bus.instr_i = 16'h2004;
    push("both_bht_pred", S_PRED, {15'd0, model_ctr[7][1]});
    settle();
    push("both_bht_pc", S_PC, 16'h000C);
    tick();

    // wrap-around at 0xFFFF
    jump(16'hFFFF);
    idle();
    push("wrap_pc1", S_PC1, 16'h0000);
    settle();
    push("wrap_pc", S_PC, 16'h0000);
    tick();

    // reset mid-operation drops the redirect and reinitialises the BHT
    idle();
    RST = 1'b1;
    bus.jr_i = 1'b1;
    bus.address_jr_i = 16'h0300;
    model_reset();
    push("mid_rst_flush", S_FLUSH, 16'd0);
    settle();
    push("mid_rst_pc", S_PC, 16'h0040);
    push("mid_rst_epc", S_EPC, 16'h0000);
    tick();
    RST = 1'b0;
    jump(16'h0020);
    idle();
    bus.instr_i = 16'h2004;
    push("mid_rst_bht", S_PRED, {15'd0, model_ctr[0][1]});
    settle();
    push("mid_rst_bht_pc", S_PC, 16'h0021);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
